// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(16,11) SECDED encode sequencer:
// FSM state encoding, message/codeword widths and the reference encoder
// function used by the combinational encoder core.
package hamming_pkg;

  localparam int MSG_W = 11;
  localparam int CW_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    CAP,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  // Message bit m[k] carries data bit d(k+1). Codeword layout, MSB first:
  // d11..d5, p8, d4, d3, d2, p4, d1, p2, p1, p0 (p0 = overall parity).
  function automatic logic [CW_W-1:0] hamming_encode(input logic [MSG_W-1:0] m);
    logic p8;
    logic p4;
    logic p2;
    logic p1;
    logic p0;
    p8 = ^m[10:4];
    p4 = (^m[10:7]) ^ (^m[3:1]);
    p2 = m[10] ^ m[9] ^ m[6] ^ m[5] ^ m[3] ^ m[2] ^ m[0];
    p1 = m[10] ^ m[8] ^ m[6] ^ m[4] ^ m[3] ^ m[1] ^ m[0];
    p0 = (^m) ^ p8 ^ p4 ^ p2 ^ p1;
    return {m[10:4], p8, m[3:1], p4, m[0], p2, p1, p0};
  endfunction

endpackage

// File: rtl/hamming_enc_core.sv
// Combinational Hamming(16,11) SECDED encoder. Kept as its own block so the
// decoder/checker can reuse the exact same encoding.
module hamming_enc_core
  import hamming_pkg::*;
(
  input  logic [MSG_W-1:0] i_msg,
  output logic [CW_W-1:0]  o_code
);

  assign o_code = hamming_encode(i_msg);

endmodule

// File: rtl/hamming_enc_seq.sv
// Hamming(16,11) encode sequencer. Reads N_MSG messages (two bytes each)
// from data memory through a req/gnt port, encodes them and writes the
// 16-bit codewords back as byte pairs. Optional source-byte checking is
// enabled with the HAMMING_SRC_CHECK_EN macro (adds o_src_err and
// o_src_err_cnt).
module hamming_enc_seq
  import hamming_pkg::*;
#(
  parameter int N_MSG    = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int AW       = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  output logic          o_done,
  output logic          o_busy,
  output logic          o_mem_req,
  input  logic          i_mem_gnt,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_we,
  output logic [7:0]    o_mem_wdata,
  input  logic [7:0]    i_mem_rdata
`ifdef HAMMING_SRC_CHECK_EN
  ,
  output logic          o_src_err,
  output logic [7:0]    o_src_err_cnt
`endif
);

  localparam int IDX_W = (N_MSG > 1) ? $clog2(N_MSG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MSG - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [7:0]        r_lo;
  logic [7:0]        w_lo_nxt;
  logic [2:0]        r_hi;
  logic [2:0]        w_hi_nxt;
  logic              r_rd_vld;
  logic              r_rd_hi;
  logic              r_done;
  logic              r_busy;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [AW-1:0]     r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic              w_done_nxt;
  logic              w_busy_nxt;
  logic              w_req_nxt;
  logic              w_we_nxt;
  logic [AW-1:0]     w_addr_nxt;
  logic [7:0]        w_wdata_nxt;
  logic [AW-1:0]     w_src_addr;
  logic [AW-1:0]     w_dst_addr;
  logic [CW_W-1:0]   w_code;
  logic              w_start_ok;
  logic              w_hi_cap;

  assign w_start_ok = i_start && ((r_state == IDLE) || (r_state == DONE));
  assign w_hi_cap   = r_rd_vld && r_rd_hi;
  assign w_src_addr = AW'(SRC_BASE) + (AW'(w_idx_nxt) << 1);
  assign w_dst_addr = AW'(DST_BASE) + (AW'(w_idx_nxt) << 1);

  assign o_done      = r_done;
  assign o_busy      = r_busy;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

  // Encoder sees the bytes as they will be after this edge's capture, so the
  // registered write data is already correct when WR_LO is entered.
  hamming_enc_core u_enc_core (
    .i_msg  ({w_hi_nxt, w_lo_nxt}),
    .o_code (w_code)
  );

  // State and message-index register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state logic; memory states hold until the arbiter grants.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      IDLE, DONE: begin
        if (i_start) begin
          w_state_nxt = RD_LO;
          w_idx_nxt   = '0;
        end
      end
      RD_LO:   if (i_mem_gnt) w_state_nxt = RD_HI;
      RD_HI:   if (i_mem_gnt) w_state_nxt = CAP;
      CAP:     w_state_nxt = WR_LO;
      WR_LO:   if (i_mem_gnt) w_state_nxt = WR_HI;
      WR_HI: begin
        if (i_mem_gnt) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = RD_LO;
            w_idx_nxt   = r_idx + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode from the upcoming state; address/data hold otherwise.
  always_comb begin
    w_done_nxt  = 1'b0;
    w_busy_nxt  = 1'b1;
    w_req_nxt   = 1'b0;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_mem_addr;
    w_wdata_nxt = r_mem_wdata;
    case (w_state_nxt)
      IDLE: w_busy_nxt = 1'b0;
      DONE: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b1;
      end
      RD_LO: begin
        w_req_nxt  = 1'b1;
        w_addr_nxt = w_src_addr;
      end
      RD_HI: begin
        w_req_nxt  = 1'b1;
        w_addr_nxt = w_src_addr + AW'(1);
      end
      WR_LO: begin
        w_req_nxt   = 1'b1;
        w_we_nxt    = 1'b1;
        w_addr_nxt  = w_dst_addr;
        w_wdata_nxt = w_code[7:0];
      end
      WR_HI: begin
        w_req_nxt   = 1'b1;
        w_we_nxt    = 1'b1;
        w_addr_nxt  = w_dst_addr + AW'(1);
        w_wdata_nxt = w_code[15:8];
      end
      default: begin
      end
    endcase
  end

  // Registered memory-port and status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_done      <= w_done_nxt;
      r_busy      <= w_busy_nxt;
      r_mem_req   <= w_req_nxt;
      r_mem_we    <= w_we_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
    end
  end

  // Route read data to the byte named by the tag of last cycle's granted read.
  always_comb begin
    w_lo_nxt = r_lo;
    w_hi_nxt = r_hi;
    if (r_rd_vld && !r_rd_hi) w_lo_nxt = i_mem_rdata;
    if (w_hi_cap)             w_hi_nxt = i_mem_rdata[2:0];
  end

  // Read tracking and source byte capture, independent of the current grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_vld <= 1'b0;
      r_rd_hi  <= 1'b0;
      r_lo     <= '0;
      r_hi     <= '0;
    end else begin
      r_rd_vld <= r_mem_req && i_mem_gnt && !r_mem_we;
      r_rd_hi  <= (r_state == RD_HI);
      r_lo     <= w_lo_nxt;
      r_hi     <= w_hi_nxt;
    end
  end

`ifdef HAMMING_SRC_CHECK_EN
  logic       r_src_err;
  logic [7:0] r_src_err_cnt;

  assign o_src_err     = r_src_err;
  assign o_src_err_cnt = r_src_err_cnt;

  // Sticky flag and saturating count of high bytes with stray upper bits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_src_err     <= 1'b0;
      r_src_err_cnt <= '0;
    end else if (w_start_ok) begin
      r_src_err     <= 1'b0;
      r_src_err_cnt <= '0;
    end else if (w_hi_cap && (i_mem_rdata[7:3] != 5'b0)) begin
      r_src_err <= 1'b1;
      if (r_src_err_cnt != 8'hFF) r_src_err_cnt <= r_src_err_cnt + 8'd1;
    end
  end
`else
  logic w_unused_rdata;
  logic w_unused_start;
  assign w_unused_rdata = ^i_mem_rdata[7:3];
  assign w_unused_start = w_start_ok;
`endif

endmodule
